decode_cycle: RTL and testbench
===============================

// Module: decode_cycle
// PURPOSE
//  Decode stage of the 5-stage RV32I-subset pipeline; consumes the D-register outputs of fetch (InstrD, PCD, PCPlus4D).
//  Holds the register file, main/ALU control decoder and immediate extender.
//  Registers everything into the ID/EX pipeline register feeding the execute stage, which returns PCSrcE/PCTargetE to fetch.
//  Writeback port (RegWriteW/RdW/ResultW) closes the loop from the W stage.
// PARAMETERS
//  PC_W    9   width of PC and PC+4 buses (matches fetch)
//  XLEN    32  data/instruction width
//  NREGS   32  architectural registers (x0 hard-wired zero)
// PORTS
//  clk          in   1      single clock, all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  InstrD       in   32     instruction from fetch D register
//  PCD          in   PC_W   PC of InstrD
//  PCPlus4D     in   PC_W   PCD+4
//  FlushE       in   1      insert bubble into ID/EX (taken branch/jump, load-use)
//  RegWriteW    in   1      writeback enable
//  RdW          in   5      writeback destination
//  ResultW      in   XLEN   writeback data
//  Rs1D, Rs2D   out  5      combinational source indices for hazard unit
//  RegWriteE    out  1      E-stage control: register write
//  ResultSrcE   out  2      00 ALU, 01 memory, 10 PC+4
//  MemWriteE    out  1      store
//  JumpE        out  1      jal
//  BranchE      out  1      beq
//  ALUSrcE      out  1      0 RD2, 1 immediate
//  ALUControlE  out  3      000 add, 001 sub, 010 and, 011 or, 101 slt
//  IllegalE     out  1      unsupported opcode/funct captured
//  RD1E, RD2E   out  XLEN   register operands
//  ImmExtE      out  XLEN   sign-extended immediate
//  Rs1E,Rs2E,RdE out 5      register indices
//  PCE,PCPlus4E out  PC_W   forwarded PC values
// BEHAVIOUR
//  - Latency: fields of InstrD appear on E outputs exactly 1 cycle later; no internal stall.
//  - Priority per edge: rst > FlushE > capture.
//  - rst: all E outputs 0 and all 32 registers cleared in the same cycle. Reset asserted mid-operation discards the in-flight instruction; no partial state survives.
//  - FlushE: every control output (RegWriteE, MemWriteE, JumpE, BranchE, IllegalE, ResultSrcE, ALUControlE, ALUSrcE) = 0; data/index fields also 0. The result is a true nop.
//  - Regfile: 2 async read, 1 sync write on the rising edge when RegWriteW && RdW!=0.
//  - Writes to x0 are ignored; reads of x0 always return 0.
//  - Write-through bypass: read index == RdW, RegWriteW=1 and RdW!=0 -> read returns ResultW in the same cycle. This covers write and read of the same register in one cycle.
//  - Decode by opcode:
//      0000011 lw    RegW=1  ResSrc=01  ALUSrc=1  ImmI  add
//      0100011 sw    MemW=1             ALUSrc=1  ImmS  add
//      0110011 R     RegW=1  ALU per funct3/funct7[5]
//      0010011 addi  RegW=1  ALUSrc=1   ImmI  funct3 000 only
//      1100011 beq   Branch=1           ImmB  sub
//      1101111 jal   RegW=1  Jump=1  ResSrc=10  ImmJ
//  - R-type ALU map: f3 000 add/sub (f7[5]=1 -> sub), 111 and, 110 or, 010 slt.
//  - Illegal encodings: IllegalE=1 and all other control bits 0. This covers other opcodes, non-beq branch funct3, other funct3 values and an all-zero InstrD.
//  - Immediates: sign-extended from bit 31.
//      I = {20{i31}, i[31:20]}
//      S = {i[31:25], i[11:7]}
//      B = {i31, i7, i[30:25], i[11:8], 0}
//      J = {i31, i[19:12], i20, i[30:21], 0}
//    Unused immediate fields = 0.
//  - PCE/PCPlus4E carried unmodified at PC_W bits; no wrap logic here.
// STRUCTURE
//  - pipeline_pkg: opcode localparams, ALUCTL_* / RESSRC_* / IMMSRC_* encodings, typedef ctrl_t (packed control bundle) used by the decode and execute stages.
//  - Sub-module reg_file (32xXLEN, 2R1W, bypass, sync reset).
//  - Decoder, extender and ID/EX register live in decode_cycle.
// TESTING
//  1 rst=1 for 2 cycles, then idle -> all E outputs 0; RD1E for any rs = 0.
//  2 Write x5=0xDEADBEEF via W port, then decode add x7,x5,x0 (0x000283B3) -> next cycle RD1E=0xDEADBEEF, RD2E=0, RegWriteE=1, ALUControlE=000, RdE=7.
//  3 Same-cycle RegWriteW x3=0x1234 and decode addi x4,x3,-1 (0xFFF18213) -> RD1E=0x1234, ImmExtE=0xFFFFFFFF, ALUSrcE=1.
//  4 beq x1,x2,-8 (0xFE208CE3) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8; same instr with FlushE=1 -> all controls 0.
//  5 RegWriteW RdW=0 ResultW=0xFF, then decode rs1=x0 -> RD1E=0. jal x1,+16 (0x010000EF) -> JumpE=1, ResultSrcE=10, ImmExtE=16.
//  6 Opcode 0x7F and sw-funct3=111 R-type -> IllegalE=1, RegWriteE=0, MemWriteE=0. rst asserted during a lw -> outputs 0 next cycle.

Source files
------------

// File: rtl/decode_cycle_pkg.sv
// Shared decode definitions: opcodes, control encodings and the packed
// control bundle carried from decode into execute.
package decode_cycle_pkg;

   // Register index width (x0..x31)
   localparam int REG_AW = 5;

   // Supported opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // funct3 values accepted for each instruction
   localparam logic [2:0] F3_LW     = 3'b010;
   localparam logic [2:0] F3_SW     = 3'b010;
   localparam logic [2:0] F3_ADDI   = 3'b000;
   localparam logic [2:0] F3_BEQ    = 3'b000;
   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_AND    = 3'b111;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_SLT    = 3'b010;

   // ALU operation encodings seen by execute
   localparam logic [2:0] ALUCTL_ADD = 3'b000;
   localparam logic [2:0] ALUCTL_SUB = 3'b001;
   localparam logic [2:0] ALUCTL_AND = 3'b010;
   localparam logic [2:0] ALUCTL_OR  = 3'b011;
   localparam logic [2:0] ALUCTL_SLT = 3'b101;

   // Writeback result selection
   localparam logic [1:0] RESSRC_ALU = 2'b00;
   localparam logic [1:0] RESSRC_MEM = 2'b01;
   localparam logic [1:0] RESSRC_PC4 = 2'b10;

   // Immediate format selection; NONE yields a zero immediate
   typedef enum logic [2:0] {
      IMMSRC_NONE = 3'd0,
      IMMSRC_I    = 3'd1,
      IMMSRC_S    = 3'd2,
      IMMSRC_B    = 3'd3,
      IMMSRC_J    = 3'd4
   } immSrc_e;

   // Control bundle travelling down the pipe with each instruction
   typedef struct packed {
      logic       regWrite;
      logic [1:0] resultSrc;
      logic       memWrite;
      logic       jump;
      logic       branch;
      logic       aluSrc;
      logic [2:0] aluControl;
      logic       illegal;
   } ctrl_t;

   // R-type ALU map; returns {legal, aluControl}
   function automatic logic [3:0] rTypeAlu(input logic [2:0] funct3, input logic funct7b5);
      case (funct3)
         F3_ADDSUB: return {1'b1, (funct7b5 ? ALUCTL_SUB : ALUCTL_ADD)};
         F3_AND:    return {1'b1, ALUCTL_AND};
         F3_OR:     return {1'b1, ALUCTL_OR};
         F3_SLT:    return {1'b1, ALUCTL_SLT};
         default:   return {1'b0, ALUCTL_ADD};
      endcase
   endfunction

endpackage

// File: rtl/decode_cycle_reg_file.sv
// Architectural register file: 2 asynchronous read ports, 1 synchronous
// write port, x0 hard-wired to zero, write-through bypass so a register
// written this cycle is read with its new value in the same cycle.
module decode_cycle_reg_file
   import decode_cycle_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = REG_AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rdAddr1,
   input  logic [AW-1:0]   rdAddr2,
   output logic [XLEN-1:0] rdData1,
   output logic [XLEN-1:0] rdData2,
   input  logic            wrEn,
   input  logic [AW-1:0]   wrAddr,
   input  logic [XLEN-1:0] wrData
);

   logic [NREGS-1:0][XLEN-1:0] regs;
   logic                       wrValid;

   // A write to x0 is not a write at all
   assign wrValid = wrEn && (wrAddr != '0);

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : gCell
         if (gi == 0) begin : gZero
            assign regs[gi] = '0;
         end else begin : gReg
            logic [XLEN-1:0] cellReg;
            // Clear on reset, otherwise capture writeback data when addressed
            always_ff @(posedge clk) begin
               if (rst) begin
                  cellReg <= '0;
               end else if (wrValid && (wrAddr == AW'(gi))) begin
                  cellReg <= wrData;
               end
            end
            assign regs[gi] = cellReg;
         end
      end
   endgenerate

   // Read port 1 with x0 forcing and same-cycle writeback bypass
   always_comb begin
      rdData1 = regs[rdAddr1];
      if (rdAddr1 == '0) begin
         rdData1 = '0;
      end else if (wrValid && (wrAddr == rdAddr1)) begin
         rdData1 = wrData;
      end
   end

   // Read port 2 with x0 forcing and same-cycle writeback bypass
   always_comb begin
      rdData2 = regs[rdAddr2];
      if (rdAddr2 == '0) begin
         rdData2 = '0;
      end else if (wrValid && (wrAddr == rdAddr2)) begin
         rdData2 = wrData;
      end
   end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: control decoder, immediate extender, register file and the
// ID/EX pipeline register feeding execute. Fields of InstrD appear on the
// E outputs one cycle later; FlushE and rst turn the slot into a nop.
module decode_cycle
   import decode_cycle_pkg::*;
#(
   parameter int PC_W  = 9,
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     InstrD,
   input  logic [PC_W-1:0] PCD,
   input  logic [PC_W-1:0] PCPlus4D,
   input  logic            FlushE,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   input  logic [XLEN-1:0] ResultW,
   output logic [4:0]      Rs1D,
   output logic [4:0]      Rs2D,
   output logic            RegWriteE,
   output logic [1:0]      ResultSrcE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic [2:0]      ALUControlE,
   output logic            IllegalE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE,
   output logic [PC_W-1:0] PCE,
   output logic [PC_W-1:0] PCPlus4E
);

   // Instruction fields
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7b5;
   logic [4:0]      rdD;

   // Decode-stage results
   ctrl_t           ctrlD;
   immSrc_e         immSrcD;
   logic [3:0]      aluR;
   logic [XLEN-1:0] immExtD;
   logic [XLEN-1:0] rd1D;
   logic [XLEN-1:0] rd2D;

   // ID/EX pipeline register
   ctrl_t           ctrlEReg;
   logic [XLEN-1:0] rd1EReg;
   logic [XLEN-1:0] rd2EReg;
   logic [XLEN-1:0] immExtEReg;
   logic [4:0]      rs1EReg;
   logic [4:0]      rs2EReg;
   logic [4:0]      rdEReg;
   logic [PC_W-1:0] pcEReg;
   logic [PC_W-1:0] pcPlus4EReg;

   assign opcode   = InstrD[6:0];
   assign funct3   = InstrD[14:12];
   assign funct7b5 = InstrD[30];
   assign rdD      = InstrD[11:7];
   assign Rs1D     = InstrD[19:15];
   assign Rs2D     = InstrD[24:20];

   decode_cycle_reg_file #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (REG_AW)
   ) uRegFile (
      .clk     (clk),
      .rst     (rst),
      .rdAddr1 (Rs1D),
      .rdAddr2 (Rs2D),
      .rdData1 (rd1D),
      .rdData2 (rd2D),
      .wrEn    (RegWriteW),
      .wrAddr  (RdW),
      .wrData  (ResultW)
   );

   // Main/ALU decoder; any unsupported encoding raises only the illegal flag
   always_comb begin
      ctrlD   = '0;
      immSrcD = IMMSRC_NONE;
      aluR    = rTypeAlu(funct3, funct7b5);
      case (opcode)
         OP_LOAD: begin
            if (funct3 == F3_LW) begin
               ctrlD.regWrite   = 1'b1;
               ctrlD.resultSrc  = RESSRC_MEM;
               ctrlD.aluSrc     = 1'b1;
               ctrlD.aluControl = ALUCTL_ADD;
               immSrcD          = IMMSRC_I;
            end else begin
               ctrlD.illegal = 1'b1;
            end
         end
         OP_STORE: begin
            if (funct3 == F3_SW) begin
               ctrlD.memWrite   = 1'b1;
               ctrlD.aluSrc     = 1'b1;
               ctrlD.aluControl = ALUCTL_ADD;
               immSrcD          = IMMSRC_S;
            end else begin
               ctrlD.illegal = 1'b1;
            end
         end
         OP_RTYPE: begin
            if (aluR[3]) begin
               ctrlD.regWrite   = 1'b1;
               ctrlD.resultSrc  = RESSRC_ALU;
               ctrlD.aluControl = aluR[2:0];
            end else begin
               ctrlD.illegal = 1'b1;
            end
         end
         OP_OPIMM: begin
            if (funct3 == F3_ADDI) begin
               ctrlD.regWrite   = 1'b1;
               ctrlD.aluSrc     = 1'b1;
               ctrlD.aluControl = ALUCTL_ADD;
               immSrcD          = IMMSRC_I;
            end else begin
               ctrlD.illegal = 1'b1;
            end
         end
         OP_BRANCH: begin
            if (funct3 == F3_BEQ) begin
               ctrlD.branch     = 1'b1;
               ctrlD.aluControl = ALUCTL_SUB;
               immSrcD          = IMMSRC_B;
            end else begin
               ctrlD.illegal = 1'b1;
            end
         end
         OP_JAL: begin
            ctrlD.regWrite  = 1'b1;
            ctrlD.jump      = 1'b1;
            ctrlD.resultSrc = RESSRC_PC4;
            immSrcD         = IMMSRC_J;
         end
         default: begin
            ctrlD.illegal = 1'b1;
         end
      endcase
   end

   // Immediate extender: every format is sign-extended from bit 31
   always_comb begin
      immExtD = '0;
      case (immSrcD)
         IMMSRC_I: immExtD = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
         IMMSRC_S: immExtD = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMMSRC_B: immExtD = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                              InstrD[30:25], InstrD[11:8], 1'b0};
         IMMSRC_J: immExtD = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                              InstrD[20], InstrD[30:21], 1'b0};
         default:  immExtD = '0;
      endcase
   end

   // ID/EX register: reset and flush both load a full nop, otherwise capture
   always_ff @(posedge clk) begin
      if (rst || FlushE) begin
         ctrlEReg    <= '0;
         rd1EReg     <= '0;
         rd2EReg     <= '0;
         immExtEReg  <= '0;
         rs1EReg     <= '0;
         rs2EReg     <= '0;
         rdEReg      <= '0;
         pcEReg      <= '0;
         pcPlus4EReg <= '0;
      end else begin
         ctrlEReg    <= ctrlD;
         rd1EReg     <= rd1D;
         rd2EReg     <= rd2D;
         immExtEReg  <= immExtD;
         rs1EReg     <= Rs1D;
         rs2EReg     <= Rs2D;
         rdEReg      <= rdD;
         pcEReg      <= PCD;
         pcPlus4EReg <= PCPlus4D;
      end
   end

   assign RegWriteE   = ctrlEReg.regWrite;
   assign ResultSrcE  = ctrlEReg.resultSrc;
   assign MemWriteE   = ctrlEReg.memWrite;
   assign JumpE       = ctrlEReg.jump;
   assign BranchE     = ctrlEReg.branch;
   assign ALUSrcE     = ctrlEReg.aluSrc;
   assign ALUControlE = ctrlEReg.aluControl;
   assign IllegalE    = ctrlEReg.illegal;
   assign RD1E        = rd1EReg;
   assign RD2E        = rd2EReg;
   assign ImmExtE     = immExtEReg;
   assign Rs1E        = rs1EReg;
   assign Rs2E        = rs2EReg;
   assign RdE         = rdEReg;
   assign PCE         = pcEReg;
   assign PCPlus4E    = pcPlus4EReg;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: reset checks, a table of directed vectors with
// hand-derived expectations, a reset-during-lw sequence and randomized
// traffic checked against a behavioural register-file/decoder model.
module tb_decode_cycle;

   localparam int PC_W = 9;
   localparam int XLEN = 32;
   localparam int NT   = 18;
   localparam int NRND = 400;

   logic            clk = 1'b0;
   logic            rst;
   logic [31:0]     InstrD;
   logic [PC_W-1:0] PCD, PCPlus4D;
   logic            FlushE, RegWriteW;
   logic [4:0]      RdW;
   logic [XLEN-1:0] ResultW;
   logic [4:0]      Rs1D, Rs2D;
   logic            RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
   logic [1:0]      ResultSrcE;
   logic [2:0]      ALUControlE;
   logic [XLEN-1:0] RD1E, RD2E, ImmExtE;
   logic [4:0]      Rs1E, Rs2E, RdE;
   logic [PC_W-1:0] PCE, PCPlus4E;

   always #5 clk = ~clk;

   decode_cycle #(.PC_W(PC_W), .XLEN(XLEN), .NREGS(32)) dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
      .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
      .ALUControlE(ALUControlE), .IllegalE(IllegalE), .RD1E(RD1E), .RD2E(RD2E),
      .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE),
      .PCPlus4E(PCPlus4E)
   );

   typedef struct packed {
      logic        regW;
      logic [1:0]  resSrc;
      logic        memW, jump, branch, aluSrc;
      logic [2:0]  aluCtl;
      logic        ill;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [PC_W-1:0] pc, pc4;
   } eOut_t;

   typedef struct packed {
      logic [31:0] instr;
      logic        flush, wen;
      logic [4:0]  wrd;
      logic [31:0] wdata;
      logic        regW;
      logic [1:0]  resSrc;
      logic        memW, jump, branch, aluSrc;
      logic [2:0]  aluCtl;
      logic        ill;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rd;
   } vec_t;

   vec_t            tbl [NT];
   logic [31:0]     mregs [32];
   logic [PC_W-1:0] pcCnt;
   int              nCmp = 0;
   int              nBad = 0;
   int              txn = 0;

   function automatic eOut_t dutE();
      return {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
              IllegalE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E};
   endfunction

   function automatic logic [31:0] mRead(input logic [4:0] a, input logic wen,
                                         input logic [4:0] wa, input logic [31:0] wd);
      if (a == 5'd0) return 32'd0;
      if (wen && wa == a) return wd;
      return mregs[a];
   endfunction

   // Behavioural model of one decode slot, straight from the instruction table
   function automatic eOut_t model(input logic [31:0] ins, input logic [PC_W-1:0] pc,
                                   input logic [PC_W-1:0] pc4, input logic fl, input logic rs,
                                   input logic wen, input logic [4:0] wa, input logic [31:0] wd);
      eOut_t       e;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] sI, sS, sB, sJ;
      e  = '0;
      if (rs || fl) return e;
      op = ins[6:0];
      f3 = ins[14:12];
      sI = $signed(ins) >>> 20;
      sS = $signed({ins[31:25], ins[11:7], 20'h0}) >>> 20;
      sB = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'h0}) >>> 19;
      sJ = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'h0}) >>> 11;
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.rd  = ins[11:7];
      e.rd1 = mRead(ins[19:15], wen, wa, wd);
      e.rd2 = mRead(ins[24:20], wen, wa, wd);
      e.pc  = pc;
      e.pc4 = pc4;
      case (op)
         7'h03: if (f3 == 3'd2) begin e.regW = 1; e.resSrc = 2'd1; e.aluSrc = 1; e.imm = sI; end
                else e.ill = 1;
         7'h23: if (f3 == 3'd2) begin e.memW = 1; e.aluSrc = 1; e.imm = sS; end
                else e.ill = 1;
         7'h13: if (f3 == 3'd0) begin e.regW = 1; e.aluSrc = 1; e.imm = sI; end
                else e.ill = 1;
         7'h63: if (f3 == 3'd0) begin e.branch = 1; e.aluCtl = 3'd1; e.imm = sB; end
                else e.ill = 1;
         7'h6F: begin e.regW = 1; e.jump = 1; e.resSrc = 2'd2; e.imm = sJ; end
         7'h33: begin
            case (f3)
               3'd0: e.aluCtl = ins[30] ? 3'd1 : 3'd0;
               3'd7: e.aluCtl = 3'd2;
               3'd6: e.aluCtl = 3'd3;
               3'd2: e.aluCtl = 3'd5;
               default: e.ill = 1;
            endcase
            e.regW = !e.ill;
         end
         default: e.ill = 1;
      endcase
      return e;
   endfunction

   task automatic cmpE(input string name, input eOut_t got, input eOut_t exp);
      nCmp++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic cmpV(input string name, input logic [31:0] got, input logic [31:0] exp);
      nCmp++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // One clocked decode slot; also advances the model register file
   task automatic step(input logic [31:0] ins, input logic fl, input logic rs, input logic wen,
                       input logic [4:0] wa, input logic [31:0] wd,
                       output eOut_t got, output eOut_t exp);
      rst = rs; InstrD = ins; PCD = pcCnt; PCPlus4D = pcCnt + PC_W'(4);
      FlushE = fl; RegWriteW = wen; RdW = wa; ResultW = wd;
      exp = model(ins, pcCnt, pcCnt + PC_W'(4), fl, rs, wen, wa, wd);
      #1;
      cmpV("rs_idx_D", {22'd0, Rs1D, Rs2D}, {22'd0, ins[19:15], ins[24:20]});
      @(posedge clk); #1;
      got = dutE();
      if (rs) begin
         for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
      end else if (wen && wa != 5'd0) begin
         mregs[wa] = wd;
      end
      pcCnt = pcCnt + PC_W'(4);
      txn++;
      $display("txn %0d instr=%h flush=%0b rst=%0b wb=%0b x%0d=%h -> E=%h",
               txn, ins, fl, rs, wen, wa, wd, got);
   endtask

   initial begin
      eOut_t got, exp, texp;
      logic [31:0] ins;
      logic [6:0]  opsTbl [6];
      logic [2:0]  rf3 [4];
      logic        fl, rs, wen;
      logic [4:0]  wa;
      logic [31:0] wd;
      int          k;

      //            instr        fl wen wrd  wdata        rW rs  mW j  b  aS ctl ill rd1          rd2          imm          rd
      tbl[0]  = '{32'h00000000, 0, 0, 5'd0, 32'h0,        0, 2'd0, 0, 0, 0, 0, 3'd0, 1, 32'h0,        32'h0,        32'h0,        5'd0};
      tbl[1]  = '{32'h00000000, 0, 1, 5'd5, 32'hDEADBEEF, 0, 2'd0, 0, 0, 0, 0, 3'd0, 1, 32'h0,        32'h0,        32'h0,        5'd0};
      tbl[2]  = '{32'h000283B3, 0, 0, 5'd0, 32'h0,        1, 2'd0, 0, 0, 0, 0, 3'd0, 0, 32'hDEADBEEF, 32'h0,        32'h0,        5'd7};
      tbl[3]  = '{32'hFFF18213, 0, 1, 5'd3, 32'h1234,     1, 2'd0, 0, 0, 0, 1, 3'd0, 0, 32'h1234,     32'h0,        32'hFFFFFFFF, 5'd4};
      tbl[4]  = '{32'hFE208CE3, 0, 0, 5'd0, 32'h0,        0, 2'd0, 0, 0, 1, 0, 3'd1, 0, 32'h0,        32'h0,        32'hFFFFFFF8, 5'd25};
      tbl[5]  = '{32'hFE208CE3, 1, 0, 5'd0, 32'h0,        0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 32'h0,        32'h0,        32'h0,        5'd0};
      tbl[6]  = '{32'h00500093, 0, 1, 5'd0, 32'hFF,       1, 2'd0, 0, 0, 0, 1, 3'd0, 0, 32'h0,        32'hDEADBEEF, 32'h5,        5'd1};
      tbl[7]  = '{32'h010000EF, 0, 0, 5'd0, 32'h0,        1, 2'd2, 0, 1, 0, 0, 3'd0, 0, 32'h0,        32'h0,        32'h10,       5'd1};
      tbl[8]  = '{32'h0000007F, 0, 0, 5'd0, 32'h0,        0, 2'd0, 0, 0, 0, 0, 3'd0, 1, 32'h0,        32'h0,        32'h0,        5'd0};
      tbl[9]  = '{32'h00507023, 0, 0, 5'd0, 32'h0,        0, 2'd0, 0, 0, 0, 0, 3'd0, 1, 32'h0,        32'hDEADBEEF, 32'h0,        5'd0};
      tbl[10] = '{32'h00001033, 0, 0, 5'd0, 32'h0,        0, 2'd0, 0, 0, 0, 0, 3'd0, 1, 32'h0,        32'h0,        32'h0,        5'd0};
      tbl[11] = '{32'h403283B3, 0, 0, 5'd0, 32'h0,        1, 2'd0, 0, 0, 0, 0, 3'd1, 0, 32'hDEADBEEF, 32'h1234,     32'h0,        5'd7};
      tbl[12] = '{32'h0081A303, 0, 0, 5'd0, 32'h0,        1, 2'd1, 0, 0, 0, 1, 3'd0, 0, 32'h1234,     32'h0,        32'h8,        5'd6};
      tbl[13] = '{32'hFE51AE23, 0, 0, 5'd0, 32'h0,        0, 2'd0, 1, 0, 0, 1, 3'd0, 0, 32'h1234,     32'hDEADBEEF, 32'hFFFFFFFC, 5'd28};
      tbl[14] = '{32'h0032F4B3, 0, 0, 5'd0, 32'h0,        1, 2'd0, 0, 0, 0, 0, 3'd2, 0, 32'hDEADBEEF, 32'h1234,     32'h0,        5'd9};
      tbl[15] = '{32'h0032E4B3, 0, 0, 5'd0, 32'h0,        1, 2'd0, 0, 0, 0, 0, 3'd3, 0, 32'hDEADBEEF, 32'h1234,     32'h0,        5'd9};
      tbl[16] = '{32'h0032A4B3, 0, 0, 5'd0, 32'h0,        1, 2'd0, 0, 0, 0, 0, 3'd5, 0, 32'hDEADBEEF, 32'h1234,     32'h0,        5'd9};
      tbl[17] = '{32'h00101093, 0, 0, 5'd0, 32'h0,        0, 2'd0, 0, 0, 0, 0, 3'd0, 1, 32'h0,        32'h0,        32'h0,        5'd1};

      opsTbl[0] = 7'h03; opsTbl[1] = 7'h23; opsTbl[2] = 7'h33;
      opsTbl[3] = 7'h13; opsTbl[4] = 7'h63; opsTbl[5] = 7'h6F;
      rf3[0] = 3'd0; rf3[1] = 3'd7; rf3[2] = 3'd6; rf3[3] = 3'd2;

      pcCnt = '0;
      for (int r = 0; r < 32; r++) mregs[r] = 32'hX;
      rst = 1'b1; InstrD = 32'h0; PCD = '0; PCPlus4D = '0; FlushE = 1'b0;
      RegWriteW = 1'b0; RdW = '0; ResultW = '0;
      @(posedge clk); #1;

      // Reset held for two cycles with live traffic: E outputs stay zero
      for (int c = 0; c < 2; c++) begin
         step(32'h000283B3, 0, 1, 1, 5'd5, 32'h55, got, exp);
         cmpE("reset_hold", got, '0);
      end

      // After reset every register reads zero
      step(32'h0032F4B3, 0, 0, 0, 5'd0, 32'h0, got, exp);
      cmpV("post_reset_rd1", got.rd1, 32'h0);
      cmpV("post_reset_rd2", got.rd2, 32'h0);
      cmpE("post_reset_model", got, exp);

      // Directed table
      for (int i = 0; i < NT; i++) begin
         texp = '0;
         if (!tbl[i].flush) begin
            texp.regW = tbl[i].regW;     texp.resSrc = tbl[i].resSrc;
            texp.memW = tbl[i].memW;     texp.jump   = tbl[i].jump;
            texp.branch = tbl[i].branch; texp.aluSrc = tbl[i].aluSrc;
            texp.aluCtl = tbl[i].aluCtl; texp.ill    = tbl[i].ill;
            texp.rd1 = tbl[i].rd1; texp.rd2 = tbl[i].rd2; texp.imm = tbl[i].imm;
            texp.rs1 = tbl[i].instr[19:15];
            texp.rs2 = tbl[i].instr[24:20];
            texp.rd  = tbl[i].rd;
            texp.pc  = pcCnt;
            texp.pc4 = pcCnt + PC_W'(4);
         end
         step(tbl[i].instr, tbl[i].flush, 0, tbl[i].wen, tbl[i].wrd, tbl[i].wdata, got, exp);
         cmpE($sformatf("table_%0d", i), got, texp);
         cmpE($sformatf("table_model_%0d", i), got, exp);
      end

      // Reset arriving with a lw in flight discards it and clears registers
      step(32'h00000013, 0, 0, 1, 5'd3, 32'hCAFE, got, exp);
      step(32'h0081A303, 0, 1, 0, 5'd0, 32'h0, got, exp);
      cmpE("rst_during_lw", got, '0);
      step(32'h003183B3, 0, 0, 0, 5'd0, 32'h0, got, exp);
      cmpV("after_rst_x3", got.rd1, 32'h0);
      cmpV("after_rst_ctl", {29'd0, got.regW, got.ill, got.jump}, {29'd0, 1'b1, 1'b0, 1'b0});
      cmpE("after_rst_model", got, exp);

      // Randomized traffic against the model
      for (int n = 0; n < NRND; n++) begin
         ins = $urandom();
         k   = int'($urandom_range(0, 6));
         if (k < 6) begin
            ins[6:0] = opsTbl[k];
            if ($urandom_range(0, 2) != 0) begin
               case (k)
                  0, 1:    ins[14:12] = 3'd2;
                  2:       ins[14:12] = rf3[$urandom_range(0, 3)];
                  default: ins[14:12] = 3'd0;
               endcase
            end
         end
         fl  = ($urandom_range(0, 7) == 0);
         rs  = ($urandom_range(0, 49) == 0);
         wen = ($urandom_range(0, 1) == 1);
         wa  = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) wa = ins[19:15];
         wd  = $urandom();
         step(ins, fl, rs, wen, wa, wd, got, exp);
         cmpE($sformatf("random_%0d", n), got, exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
